// File: rtl/rom_dl_arbiter.sv
// rtl/rom_dl_arbiter.sv - ROM RAM download sequencer and CPU/video read arbiter
//
// Owns the single-port program/graphics ROM RAM. Download writes from the HPS
// ioctl stream always win the RAM port; the core is held in reset while a
// download is active and for RST_HOLD cycles after it ends. In RUN the read
// port is shared between CPU and video with a req/ack handshake (one grant per
// cycle, ack one cycle after the grant, round-robin on ties).
//
// Optional feature: define ROM_CHECKSUM_EN to build the index-0 byte checksum
// on dl_csum; otherwise dl_csum is tied to 0.
//
// Ports:
//   clk_sys, reset_n                      clock, synchronous active-low reset
//   dl_active/dl_wr/dl_addr/dl_data/dl_index   ioctl download stream
//   cpu_req/cpu_addr -> cpu_ack/cpu_data   CPU read channel
//   vid_req/vid_addr -> vid_ack/vid_data   video read channel
//   mem_addr/mem_din/mem_we <- mem_dout    RAM port (1-cycle read latency)
//   mod_sel, dip_sw                        bytes latched from the download
//   core_reset                             active-high reset to the game core
//   dl_bytes, dl_oor, dl_csum              index-0 download statistics
module rom_dl_arbiter #(
  parameter int AW        = 16,
  parameter int RST_HOLD  = 16,
  parameter int MOD_INDEX = 1,
  parameter int DIP_INDEX = 254
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [24:0]   dl_addr,
  input  logic [7:0]    dl_data,
  input  logic [7:0]    dl_index,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_ack,
  output logic [7:0]    cpu_data,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [7:0]    vid_data,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  output logic          mem_we,
  input  logic [7:0]    mem_dout,
  output logic [7:0]    mod_sel,
  output logic [23:0]   dip_sw,
  output logic          core_reset,
  output logic [AW:0]   dl_bytes,
  output logic          dl_oor,
  output logic [7:0]    dl_csum
);

  localparam int          CW        = $clog2(RST_HOLD + 1);
  localparam logic [AW:0] BYTES_MAX = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {ST_LOAD, ST_HOLD, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cpu_pend_q, vid_pend_q;
  logic          last_vid_q, last_vid_d;
  logic          dl_active_q;
  logic          new_sess_q, new_sess_d;
  logic [7:0]    mod_q, mod_d;
  logic [23:0]   dip_q, dip_d;
  logic [AW:0]   bytes_q, bytes_d;
  logic          oor_q, oor_d;

  logic in_range, idx0_wr, ram_wr, oor_wr, mod_wr, dip_wr;
  logic sess_start, clr_stats;
  logic can_grant, cpu_elig, vid_elig, gnt_cpu, gnt_vid;

  assign in_range = ~|(dl_addr >> AW);
  assign idx0_wr  = dl_wr && (dl_index == 8'd0);
  assign ram_wr   = idx0_wr && in_range;
  assign oor_wr   = idx0_wr && !in_range;
  assign mod_wr   = dl_wr && (dl_index == 8'(MOD_INDEX));
  assign dip_wr   = dl_wr && (dl_index == 8'(DIP_INDEX)) && (dl_addr < 25'd3);

  // A session starts at the dl_active rise and stays "fresh" until its first
  // write; the stats clear only if that first write is an index-0 byte.
  assign sess_start = (dl_active && !dl_active_q) || new_sess_q;
  assign clr_stats  = idx0_wr && sess_start;
  assign new_sess_d = dl_active && !dl_wr && sess_start;

  // dl_active gates grants combinationally so a rise blocks new reads at once;
  // an already-issued grant still acks from its pending flag.
  assign can_grant = (state_q == ST_RUN) && !dl_active && !ram_wr;
  assign cpu_elig  = cpu_req && !cpu_pend_q;
  assign vid_elig  = vid_req && !vid_pend_q;
  assign gnt_vid   = can_grant && vid_elig && (!cpu_elig || !last_vid_q);
  assign gnt_cpu   = can_grant && cpu_elig && !gnt_vid;
  assign last_vid_d = gnt_vid ? 1'b1 : (gnt_cpu ? 1'b0 : last_vid_q);

  assign mem_we   = ram_wr;
  assign mem_din  = dl_data;
  assign mem_addr = ram_wr  ? dl_addr[AW-1:0] :
                    gnt_vid ? vid_addr : cpu_addr;

  assign cpu_ack    = cpu_pend_q;
  assign vid_ack    = vid_pend_q;
  assign cpu_data   = mem_dout;
  assign vid_data   = mem_dout;
  assign core_reset = (state_q != ST_RUN) || dl_active;
  assign mod_sel    = mod_q;
  assign dip_sw     = dip_q;
  assign dl_bytes   = bytes_q;
  assign dl_oor     = oor_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (dl_active) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: begin
          state_d = ST_HOLD;
          cnt_d   = CW'(RST_HOLD);
        end
        ST_HOLD: begin
          // Leaving when the count would reach 0 gives exactly RST_HOLD cycles.
          if (cnt_q <= CW'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    mod_d   = mod_wr ? dl_data : mod_q;
    dip_d   = dip_q;
    bytes_d = clr_stats ? '0 : bytes_q;
    oor_d   = clr_stats ? 1'b0 : oor_q;
    if (dip_wr) begin
      case (dl_addr[1:0])
        2'd0:    dip_d[7:0]   = dl_data;
        2'd1:    dip_d[15:8]  = dl_data;
        default: dip_d[23:16] = dl_data;
      endcase
    end
    if (ram_wr && (bytes_d != BYTES_MAX)) bytes_d = bytes_d + 1'b1;
    if (oor_wr) oor_d = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q     <= ST_HOLD;
      cnt_q       <= CW'(RST_HOLD);
      cpu_pend_q  <= 1'b0;
      vid_pend_q  <= 1'b0;
      last_vid_q  <= 1'b0;
      dl_active_q <= 1'b0;
      new_sess_q  <= 1'b0;
      mod_q       <= 8'h00;
      dip_q       <= 24'hFFFFFF;
      bytes_q     <= '0;
      oor_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpu_pend_q  <= gnt_cpu;
      vid_pend_q  <= gnt_vid;
      last_vid_q  <= last_vid_d;
      dl_active_q <= dl_active;
      new_sess_q  <= new_sess_d;
      mod_q       <= mod_d;
      dip_q       <= dip_d;
      bytes_q     <= bytes_d;
      oor_q       <= oor_d;
    end
  end

`ifdef ROM_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = clr_stats ? 8'h00 : csum_q;
    if (ram_wr) csum_d = csum_d + dl_data;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) csum_q <= 8'h00;
    else          csum_q <= csum_d;
  end

  assign dl_csum = csum_q;
`else
  assign dl_csum = 8'h00;
`endif

endmodule
